// File: rtl/fpadd_pkg.sv
// Shared types and constants for the fpadd arbiter slice.
package fpadd_pkg;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;

    localparam int FLG_NV = 4;
    localparam int FLG_DZ = 3;
    localparam int FLG_OF = 2;
    localparam int FLG_UF = 1;
    localparam int FLG_NX = 0;

    typedef struct packed {
        logic [63:0] op1;
        logic [63:0] op2;
        logic [2:0]  rm;
        logic [2:0]  op_type;
        logic        p;
    } fpadd_req_t;

endpackage

// File: rtl/fpadd_arb_fpadd.sv
// Combinational IEEE-754 add/sub, single (left-aligned) or double.
module fpadd
    import fpadd_pkg::*;
(
    input  logic [63:0] op1_i,
    input  logic [63:0] op2_i,
    input  logic [2:0]  rm_i,
    input  logic [2:0]  op_type_i,
    input  logic        p_i,
    input  logic        oven_i,
    input  logic        unen_i,
    output logic [63:0] result_o,
    output logic [4:0]  flags_o,
    output logic        denorm_o
);

    logic [51:0]        fa, fb, fo;
    logic [10:0]        xa, xb, ea, eb, emax, el, es, d, lim, eo;
    logic [52:0]        ma, mb, ml, ms;
    logic               sa, sb, sl, sub, swap, effsub;
    logic               nan_a, nan_b, inf_a, inf_b, snan;
    logic [5:0]         dc, lz, sh;
    logic [111:0]       wide;
    logic [55:0]        al, n, lmask, half, one, mf;
    logic [56:0]        sum, r;
    logic               stk, rb, st, lsb, inc, nx, ovf, tiny, zs;
    logic signed [12:0] en, ef, adj;

    always_comb begin
        sub  = (op_type_i == OP_SUB);
        emax = p_i ? 11'd255 : 11'd2047;
        adj  = p_i ? 13'sd192 : 13'sd1536;
        fa   = p_i ? {op1_i[54:32], 29'b0} : op1_i[51:0];
        fb   = p_i ? {op2_i[54:32], 29'b0} : op2_i[51:0];
        xa   = p_i ? {3'b0, op1_i[62:55]} : op1_i[62:52];
        xb   = p_i ? {3'b0, op2_i[62:55]} : op2_i[62:52];
        sa   = op1_i[63];
        sb   = op2_i[63] ^ sub;

        nan_a = (xa == emax) && (fa != '0);
        nan_b = (xb == emax) && (fb != '0);
        inf_a = (xa == emax) && (fa == '0);
        inf_b = (xb == emax) && (fb == '0);
        snan  = (nan_a && !fa[51]) || (nan_b && !fb[51]);

        ma = {xa != '0, fa};
        mb = {xb != '0, fb};
        ea = (xa == '0) ? 11'd1 : xa;
        eb = (xb == '0) ? 11'd1 : xb;

        swap   = {eb, mb} > {ea, ma};
        el     = swap ? eb : ea;
        es     = swap ? ea : eb;
        ml     = swap ? mb : ma;
        ms     = swap ? ma : mb;
        sl     = swap ? sb : sa;
        effsub = sa ^ sb;

        // Align the smaller operand; shifted-out bits fold into a sticky LSB.
        d    = el - es;
        dc   = (d > 11'd56) ? 6'd56 : d[5:0];
        wide = {ms, 3'b000, 56'b0} >> dc;
        stk  = |wide[55:0];
        al   = {wide[111:57], wide[56] | stk};
        sum  = effsub ? ({1'b0, ml, 3'b000} - {1'b0, al})
                      : ({1'b0, ml, 3'b000} + {1'b0, al});

        lz = 6'd56;
        for (int i = 0; i < 56; i++) begin
            if (sum[i]) lz = 6'(55 - i);
        end

        lim = el - 11'd1;
        sh  = (unen_i || ({5'b0, lz} <= lim)) ? lz : lim[5:0];
        if (sum[56]) begin
            n  = {sum[56:2], sum[1] | sum[0]};
            en = $signed({2'b00, el}) + 13'sd1;
        end else begin
            n  = sum[55:0] << sh;
            en = $signed({2'b00, el}) - $signed({7'b0, sh});
        end

        lmask = p_i ? 56'h00_0000_FFFF_FFFF : 56'h7;
        half  = p_i ? 56'h00_0000_8000_0000 : 56'h4;
        one   = p_i ? 56'h00_0001_0000_0000 : 56'h8;
        rb    = |(n & half);
        st    = |(n & lmask & ~half);
        lsb   = |(n & one);
        nx    = rb | st;

        case (rm_i)
            RM_RNE:  inc = rb & (st | lsb);
            RM_RTZ:  inc = 1'b0;
            RM_RDN:  inc = sl & nx;
            RM_RUP:  inc = ~sl & nx;
            RM_RMM:  inc = rb;
            default: inc = 1'b0;
        endcase

        r    = {1'b0, n & ~lmask} + (inc ? {1'b0, one} : 57'd0);
        mf   = r[56] ? r[56:1] : r[55:0];
        ef   = r[56] ? en + 13'sd1 : en;
        ovf  = ef >= $signed({2'b00, emax});
        tiny = unen_i ? (ef < 13'sd1) : ~mf[55];
        zs   = effsub ? (rm_i == RM_RDN) : sa;

        flags_o  = '0;
        denorm_o = 1'b0;
        fo       = mf[54:3];
        eo       = mf[55] ? 11'(ef) : 11'd0;

        if (ovf) begin
            flags_o[FLG_OF] = 1'b1;
            flags_o[FLG_NX] = 1'b1;
            if (oven_i) begin
                eo = 11'(ef - adj);
            end else if ((rm_i == RM_RTZ) || (rm_i == RM_RDN && !sl)
                         || (rm_i == RM_RUP && sl)) begin
                eo = emax - 11'd1;
                fo = '1;
            end else begin
                eo = emax;
                fo = '0;
            end
        end else begin
            flags_o[FLG_NX] = nx;
            if (tiny && unen_i) begin
                flags_o[FLG_UF] = 1'b1;
                eo = 11'(ef + adj);
            end else begin
                flags_o[FLG_UF] = tiny & nx;
                denorm_o = ~mf[55];
            end
        end

        result_o = p_i ? {sl, eo[7:0], fo[51:29], 32'b0} : {sl, eo, fo};

        if (nan_a || nan_b || (inf_a && inf_b && effsub)) begin
            flags_o  = '0;
            flags_o[FLG_NV] = snan | (inf_a & inf_b & effsub);
            denorm_o = 1'b0;
            result_o = p_i ? {1'b0, 8'hff, 1'b1, 54'b0}
                           : {1'b0, 11'h7ff, 1'b1, 51'b0};
        end else if (inf_a || inf_b) begin
            flags_o  = '0;
            denorm_o = 1'b0;
            result_o = p_i ? {inf_a ? sa : sb, 8'hff, 55'b0}
                           : {inf_a ? sa : sb, 11'h7ff, 52'b0};
        end else if (sum == '0) begin
            flags_o  = '0;
            denorm_o = 1'b0;
            result_o = {zs, 63'b0};
        end
    end

endmodule

// File: rtl/fpadd_arb.sv
// Round-robin two-requester front end sharing one combinational fpadd.
module fpadd_arb
    import fpadd_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int CNTW = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [1:0][63:0]     req_op1,
    input  logic [1:0][63:0]     req_op2,
    input  logic [1:0][2:0]      req_rm,
    input  logic [1:0][2:0]      req_op_type,
    input  logic [1:0]           req_p,
    input  logic                 oven,
    input  logic                 unen,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_id,
    output logic [63:0]          rsp_result,
    output logic [4:0]           rsp_flags,
    output logic                 rsp_denorm,
    output logic                 busy,
    output logic [CNTW-1:0]      op_count
);

    state_t          state_q;
    logic            last_grant_q;
    fpadd_req_t      opreg_q;
    fpadd_req_t      sel_d;
    logic            oven_q, unen_q, id_q;
    logic            rsp_id_q, rsp_denorm_q;
    logic [63:0]     rsp_result_q;
    logic [4:0]      rsp_flags_q;
    logic [CNTW-1:0] op_count_q;

    logic            gnt_id, take;
    logic [1:0]      gnt_vec;
    logic [63:0]     fa_res;
    logic [4:0]      fa_flg;
    logic            fa_dn;

    // On a tie the requester that did not win last time is favoured.
    always_comb begin
        gnt_id = req_valid[1];
        if (req_valid == 2'b11) gnt_id = ~last_grant_q;
        gnt_vec = 2'b00;
        gnt_vec[gnt_id] = 1'b1;
        req_ready = (state_q == IDLE && !reset) ? (req_valid & gnt_vec) : 2'b00;
        take = |req_ready;
        sel_d.op1     = req_op1[gnt_id];
        sel_d.op2     = req_op2[gnt_id];
        sel_d.rm      = req_rm[gnt_id];
        sel_d.op_type = req_op_type[gnt_id];
        sel_d.p       = req_p[gnt_id];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            opreg_q      <= '0;
            oven_q       <= 1'b0;
            unen_q       <= 1'b0;
            id_q         <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
            rsp_denorm_q <= 1'b0;
            op_count_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: if (take) begin
                    opreg_q      <= sel_d;
                    oven_q       <= oven;
                    unen_q       <= unen;
                    id_q         <= gnt_id;
                    last_grant_q <= gnt_id;
                    state_q      <= EXEC;
                end
                EXEC: begin
                    rsp_id_q     <= id_q;
                    rsp_result_q <= fa_res;
                    rsp_flags_q  <= fa_flg;
                    rsp_denorm_q <= fa_dn;
                    state_q      <= RESP;
                end
                RESP: if (rsp_ready) begin
                    op_count_q <= op_count_q + CNTW'(1);
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    fpadd u_fpadd (
        .op1_i     (opreg_q.op1),
        .op2_i     (opreg_q.op2),
        .rm_i      (opreg_q.rm),
        .op_type_i (opreg_q.op_type),
        .p_i       (opreg_q.p),
        .oven_i    (oven_q),
        .unen_i    (unen_q),
        .result_o  (fa_res),
        .flags_o   (fa_flg),
        .denorm_o  (fa_dn)
    );

    assign rsp_valid  = (state_q == RESP);
    assign busy       = (state_q != IDLE);
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_flags  = rsp_flags_q;
    assign rsp_denorm = rsp_denorm_q;
    assign op_count   = op_count_q;

    a_grant_onehot: assert property (@(posedge clk) disable iff (reset)
        ($countones(req_ready) <= 1) && (NREQ == 2));

endmodule

// File: doc/fpadd_arb.md
# fpadd_arb

Two-requester arbiter and sequencer for the shared combinational `fpadd` unit. Each requester presents an add/subtract operation with a valid/ready handshake. The block grants one requester round-robin, registers its operands and controls into `fpadd`, captures result/flags/denorm into an output register, and holds the response until the consumer accepts it. It sits between the issue logic and the single `fpadd` instance, so that one adder serves two clients.

## Interface
Parameters:
- `NREQ`, 2: number of requesters; the design is fixed at 2 and the parameter exists only for assertions.
- `CNTW`, 16: width of the completed-operation counter.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  2  per-requester request valid.
- `req_ready`  out  2  per-requester accept; a request is taken when valid&ready.
- `req_op1`, `req_op2`  in  2x64  operands. Single precision (P=1) is left-aligned in [63:32] with [31:0] zero.
- `req_rm`  in  2x3  rounding mode (000=RNE).
- `req_op_type`  in  2x3  `fpadd` op_type (000=add).
- `req_p`  in  2  precision (1=single).
- `oven`, `unen`  in  1  global overflow/underflow trap enables, sampled with the operands.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  consumer accept.
- `rsp_id`  out  1  index of the requester that owns the response.
- `rsp_result`  out  64  `fpadd` result.
- `rsp_flags`  out  5  `fpadd` Flags, unmodified.
- `rsp_denorm`  out  1  `fpadd` Denorm.
- `busy`  out  1  high whenever the state is not IDLE.
- `op_count`  out  CNTW  number of completed response handshakes; wraps modulo 2^CNTW.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - `req_ready` = `req_valid` masked to the single granted requester; at most one bit is high.
  - On a handshake: latch op1/op2/rm/op_type/p/oven/unen and the grant id into the operand register, update `last_grant`, and go to EXEC.
- EXEC:
  - `fpadd` evaluates from the operand register.
  - At the clock edge, capture result/flags/denorm/id into the response register and go to RESP.
- RESP:
  - `rsp_valid`=1, and the response register is stable.
  - On `rsp_valid&rsp_ready`: increment `op_count` and go to IDLE.
  - No new request is accepted in RESP, even in the handshake cycle.
- Arbitration:
  - If only one requester is valid, it is granted.
  - If both are valid, the requester ≠ `last_grant` is granted.
  - `last_grant` resets to 1, so requester 0 wins the first tie.
  - The grant is combinational from `req_valid` and `last_grant`.
- Requesters may drop `req_valid` before they are granted; no state changes in that case.
- `rsp_*` outputs are driven only from the response register, never combinationally from `fpadd`.

## Timing
- Reset (asynchronous, at any time):
  - State→IDLE; `req_ready`=0 while `reset` is high.
  - `rsp_valid`=0, `rsp_id`=0, `rsp_result`=0, `rsp_flags`=0, `rsp_denorm`=0.
  - `busy`=0, `op_count`=0, `last_grant`=1, operand register cleared.
  - Any in-flight operation is discarded with no response.
- Latency: request handshake in cycle N → `rsp_valid` rises in cycle N+2.
- Throughput: one operation per 3 cycles with `rsp_ready` held high.
  - Handshake N, EXEC N+1, RESP/accept N+2, next handshake at N+3 at the earliest.
- Backpressure: while `rsp_ready`=0, RESP is held indefinitely with all `rsp_*` constant.
- `op_count` wraps to 0 after 2^CNTW−1 with no flag.
- When `req_valid` rises in the same cycle the FSM returns to IDLE, the request is not accepted until the following cycle.

## Structure
- Shared package `fpadd_pkg`:
  - `state_t` enum {IDLE, EXEC, RESP}.
  - Rounding-mode constants (RM_RNE=3'b000 …).
  - op_type constants (OP_ADD=3'b000 …).
  - Packed struct `fpadd_req_t` {op1, op2, rm, op_type, p}.
- One sub-module: the existing `fpadd`, instantiated once and fed from the operand register. There is no other hierarchy.

## Test plan
- Single request, requester 0: 3f800000_00000000 + 3f800000_00000000, RNE, P=1 → `rsp_valid` exactly 2 cycles after the handshake; `rsp_result`[63:32]=40000000, flags match standalone `fpadd`, `rsp_id`=0, `op_count`=1.
- Overflow: 7f7fffff+7f7fffff, RNE, requester 1 → `rsp_result`[63:32]=7f800000, `rsp_flags` identical to standalone `fpadd`, `rsp_id`=1.
- Both requesters valid continuously for 6 operations → grants alternate 0,1,0,1,0,1; `req_ready` is never high on both bits.
- Backpressure: hold `rsp_ready`=0 for 10 cycles in RESP → `rsp_*` stable, `req_ready`=0, `busy`=1; on release, exactly one handshake and `op_count` increments by 1.
- Reset asserted asynchronously mid-EXEC → all outputs go to their reset values immediately; no response appears after deassertion; the next request from requester 0 completes normally.
- Replay the f32 add RNE vector file through alternating requesters → every `rsp_result`[63:32] matches the expected value, and total completions equal the vector count.
